// File: rtl/avl_pipe.sv
// Pipelined Avalon-MM master bridge: request FIFO, in-order tracker of outstanding
// commands, combinational response path and a watchdog that drains everything as errors.
`timescale 1ns/1ps
module avl_pipe #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int DEPTH   = 4,
    parameter int OUTS    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            avl_valid,
    input  logic            avl_instr,
    input  logic [AW-1:0]   avl_addr,
    input  logic [DW-1:0]   avl_wdata,
    input  logic [DW/8-1:0] avl_wstrb,
    output logic            avl_grant,
    output logic [DW-1:0]   avl_rdata,
    output logic            avl_ready,
    output logic            avl_error,
    output logic            avl_rinstr,
    output logic            avl_timeout,
    output logic [AW-1:0]   m_avl_address,
    output logic [DW/8-1:0] m_avl_byteenable,
    output logic            m_avl_lock,
    output logic            m_avl_read,
    output logic [DW-1:0]   m_avl_writedata,
    output logic            m_avl_write,
    output logic [2:0]      m_avl_burstcount,
    input  logic [DW-1:0]   m_avl_readdata,
    input  logic [1:0]      m_avl_response,
    input  logic            m_avl_waitrequest,
    input  logic            m_avl_readdatavalid,
    input  logic            m_avl_writeresponsevalid
);

    localparam int SW  = DW / 8;
    localparam int FPW = $clog2(DEPTH);
    localparam int FCW = $clog2(DEPTH) + 1;
    localparam int TPW = (OUTS > 1) ? $clog2(OUTS) : 1;
    localparam int TCW = $clog2(OUTS) + 1;
    localparam int WW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WW-1:0] WD_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
        logic          instr;
    } req_t;

    req_t           f_mem [DEPTH];
    logic [FPW-1:0] f_wr_ptr_reg;
    logic [FPW-1:0] f_rd_ptr_reg;
    logic [FCW-1:0] f_count_reg;

    // Tracker entry: {is_write, instr} of each command accepted by the interconnect.
    logic [1:0]     t_mem [OUTS];
    logic [TPW-1:0] t_wr_ptr_reg;
    logic [TPW-1:0] t_rd_ptr_reg;
    logic [TCW-1:0] t_count_reg;

    state_t         state_reg;
    logic [WW-1:0]  wd_reg;
    logic           timeout_reg;
    logic           drain_ready_reg;
    logic           drain_instr_reg;

    logic           active;
    logic           fifo_full;
    logic           push;
    req_t           head;
    logic           head_write;
    logic           cmd;
    logic           issue;
    logic [1:0]     t_head;
    logic           t_empty;
    logic           resp_seen;
    logic           resp_err;
    logic           t_pop;
    logic           counting;
    logic           wd_fire;

    function automatic logic [TPW-1:0] t_inc(input logic [TPW-1:0] p);
        return (p == TPW'(OUTS - 1)) ? '0 : p + TPW'(1);
    endfunction

    assign active     = reset & (state_reg == RUN);
    assign fifo_full  = (f_count_reg == FCW'(DEPTH));
    assign push       = avl_valid & ~fifo_full & active;

    assign head       = f_mem[f_rd_ptr_reg];
    assign head_write = |head.wstrb;
    assign cmd        = active & (f_count_reg != '0) & (t_count_reg < TCW'(OUTS));
    assign issue      = cmd & ~m_avl_waitrequest;

    assign t_head     = t_mem[t_rd_ptr_reg];
    assign t_empty    = (t_count_reg == '0);
    assign resp_seen  = active & (m_avl_readdatavalid | m_avl_writeresponsevalid);
    assign t_pop      = resp_seen & ~t_empty;
    // A strobe with nothing outstanding, both strobes at once, or a kind that
    // disagrees with the oldest command is reported as an error.
    assign resp_err   = (m_avl_response != 2'b00) | t_empty
                      | (m_avl_readdatavalid & m_avl_writeresponsevalid)
                      | (m_avl_readdatavalid & t_head[1])
                      | (m_avl_writeresponsevalid & ~t_head[1]);

    assign counting   = active & ~t_empty & ~resp_seen;
    assign wd_fire    = (TIMEOUT != 0) & counting & (wd_reg == WD_LAST);

    always_ff @(posedge clock) begin
        if (push) begin
            f_mem[f_wr_ptr_reg] <= '{addr: avl_addr, wdata: avl_wdata, wstrb: avl_wstrb, instr: avl_instr};
        end
        if (issue) begin
            t_mem[t_wr_ptr_reg] <= {head_write, head.instr};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg       <= RUN;
            f_wr_ptr_reg    <= '0;
            f_rd_ptr_reg    <= '0;
            f_count_reg     <= '0;
            t_wr_ptr_reg    <= '0;
            t_rd_ptr_reg    <= '0;
            t_count_reg     <= '0;
            wd_reg          <= '0;
            timeout_reg     <= 1'b0;
            drain_ready_reg <= 1'b0;
            drain_instr_reg <= 1'b0;
        end else if (state_reg == RUN) begin
            drain_ready_reg <= 1'b0;
            drain_instr_reg <= 1'b0;
            if (push) begin
                f_wr_ptr_reg <= f_wr_ptr_reg + FPW'(1);
            end
            if (issue) begin
                f_rd_ptr_reg <= f_rd_ptr_reg + FPW'(1);
                t_wr_ptr_reg <= t_inc(t_wr_ptr_reg);
            end
            if (t_pop) begin
                t_rd_ptr_reg <= t_inc(t_rd_ptr_reg);
            end
            f_count_reg <= f_count_reg + FCW'(push) - FCW'(issue);
            t_count_reg <= t_count_reg + TCW'(issue) - TCW'(t_pop);
            wd_reg      <= counting ? wd_reg + WW'(1) : '0;
            if (wd_fire) begin
                state_reg   <= FAULT;
                timeout_reg <= 1'b1;
            end
        end else begin
            // Drain one pending item per cycle: outstanding commands first, then queued ones.
            if (!t_empty) begin
                t_rd_ptr_reg    <= t_inc(t_rd_ptr_reg);
                t_count_reg     <= t_count_reg - TCW'(1);
                drain_ready_reg <= 1'b1;
                drain_instr_reg <= t_head[0];
            end else if (f_count_reg != '0) begin
                f_rd_ptr_reg    <= f_rd_ptr_reg + FPW'(1);
                f_count_reg     <= f_count_reg - FCW'(1);
                drain_ready_reg <= 1'b1;
                drain_instr_reg <= head.instr;
            end else begin
                drain_ready_reg <= 1'b0;
                drain_instr_reg <= 1'b0;
            end
        end
    end

    assign avl_grant        = push;
    assign avl_ready        = resp_seen | drain_ready_reg;
    assign avl_error        = (resp_seen & resp_err) | drain_ready_reg;
    assign avl_rdata        = (resp_seen & ~resp_err & m_avl_readdatavalid) ? m_avl_readdata : '0;
    assign avl_rinstr       = resp_seen ? (~t_empty & t_head[0]) : drain_instr_reg;
    assign avl_timeout      = timeout_reg;

    assign m_avl_read       = cmd & ~head_write;
    assign m_avl_write      = cmd & head_write;
    assign m_avl_address    = cmd ? head.addr : '0;
    assign m_avl_byteenable = cmd ? (head_write ? head.wstrb : '1) : '0;
    assign m_avl_writedata  = cmd ? head.wdata : '0;
    assign m_avl_lock       = 1'b0;
    assign m_avl_burstcount = 3'd1;

endmodule
